frame_swap_share: RTL and testbench
===================================

# frame_swap_share

Double-buffered, parametrised shared memory between a host Beta (physics) and a client Beta (laser). The host builds the next display list in the back bank while the client scans the front bank. A swap handshake exchanges the banks only at a client frame boundary, so the projector never draws a half-written frame. An optional copy-on-swap mode refreshes the new back bank from the new front bank, so the host can do incremental updates. The block replaces the single-bank shared memory between the two CPUs and adds swap control, an interrupt and statistics.

## Interface
- DATA_W, 32, word width
- ADDR_W, 10, word-address bits per bank; DEPTH = 2^ADDR_W words per bank
- COPY_ON_SWAP, 0, 1 = copy front bank into back bank after every swap

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- host_we  in  1  host write strobe (already qualified by host address decode)
- host_addr  in  32  host byte address; word index = host_addr[ADDR_W+1:2]
- host_din  in  DATA_W  host write data
- host_dout  out  DATA_W  back-bank read data, registered
- host_ready  out  1  0 while a copy is in progress; host holds writes until 1
- host_swap_req  in  1  one-cycle pulse: back bank complete, request swap
- client_addr  in  32  client byte address; word index = client_addr[ADDR_W+1:2]
- client_dout  out  DATA_W  front-bank read data, registered
- client_frame_done  in  1  one-cycle pulse: client finished scanning a frame
- client_irq  out  1  one-cycle pulse when a swap takes effect
- front_sel  out  1  index of the bank currently presented to the client
- swap_pending  out  1  a swap has been requested and not yet performed
- frame_count  out  16  completed swaps, wraps at 2^16
- swap_dropped  out  8  swap requests ignored because one was already pending; saturates at 255

## Operation
- Two banks, B0 and B1. The back bank is always the bank not selected by front_sel.
- Host writes go only to the back bank. Host reads return back-bank data.
- Client accesses are read-only and return front-bank data.
- Upper address bits beyond ADDR_W+1 are ignored; addresses alias modulo DEPTH.
- FSM states: IDLE, PEND, COPY, COPY_PEND.
  - IDLE: host_swap_req -> PEND.
  - PEND: client_frame_done -> front_sel toggles and client_irq pulses. frame_count increments. Next state is COPY if COPY_ON_SWAP=1, otherwise IDLE.
  - COPY: the copy engine writes front[i] to back[i] for i = 0..DEPTH-1, one word per cycle, in ascending order. When i = DEPTH-1 is written, go to IDLE. host_swap_req -> COPY_PEND.
  - COPY_PEND: copy continues. When the copy finishes, go to PEND. client_frame_done is ignored until the copy finishes; the swap waits for the next frame_done after that.
- swap_pending = 1 in PEND and COPY_PEND.
- host_swap_req in PEND or COPY_PEND: ignored, and swap_dropped increments (saturating).
- host_swap_req and client_frame_done in the same cycle in IDLE: the request is registered (-> PEND). No swap occurs that cycle.
- In COPY and COPY_PEND:
  - host_ready = 0 and host_we is ignored.
  - host_dout is undefined.
  - Client reads stay valid, because the front bank is unchanged.
- Reset values:
  - front_sel = 0, state = IDLE
  - host_ready = 1
  - client_irq = 0, swap_pending = 0
  - frame_count = 0, swap_dropped = 0
  - host_dout = 0, client_dout = 0
  - Bank contents are not cleared.
- Reset asserted mid-copy aborts the copy immediately. Partially copied words remain.

## Timing
- Read latency is 1 cycle for both ports. An address sampled at edge t gives data valid after edge t+1.
- A host write at edge t is visible to a host read issued at t+1.
- Swap in cycle t (PEND, client_frame_done = 1):
  - front_sel flips at edge t+1, and client_irq is high for that one cycle.
  - Client reads sampled at t+1 or later return the new front bank.
  - Reads sampled at t return the old front bank.
- Copy mode:
  - host_ready falls at edge t+1 and stays 0 for exactly DEPTH cycles.
  - host_ready rises at edge t+1+DEPTH.
- Counters update on the same edge as the event that causes them.

## Test plan
- Fill back bank B1 with host writes data = addr*3, then read back via the host port. Expected: 1-cycle latency, exact values, and client reads still show B0 contents.
- Pulse host_swap_req, wait 5 cycles, then pulse client_frame_done. Expected: swap_pending high during the wait, front_sel = 1 one cycle later, a single client_irq pulse, frame_count = 1, and the client reads the B1 data.
- With PEND active, pulse host_swap_req 300 times. Expected: swap_dropped saturates at 255 and only one swap occurs on the next frame_done.
- COPY_ON_SWAP=1, ADDR_W=4: perform a swap. Expected: host_ready = 0 for exactly 16 cycles, a write attempted during the copy is dropped, and afterwards the back bank equals the front bank word for word.
- Issue a swap request during the copy, and pulse frame_done both mid-copy and after the copy. Expected: no swap mid-copy, and a swap on the first frame_done after host_ready returns.
- Assert reset at word 7 of a copy. Expected: front_sel = 0, state idle, host_ready = 1, all counters 0, with no further clock needed for outputs to reach reset values.

Source files
------------

// File: rtl/frame_swap_share_if.sv
// Host/client bus bundle for the double-buffered frame memory.
interface frame_swap_share_if #(
  parameter int DATA_W = 32
);
  logic              host_we;
  logic [31:0]       host_addr;
  logic [DATA_W-1:0] host_din;
  logic [DATA_W-1:0] host_dout;
  logic              host_ready;
  logic              host_swap_req;
  logic [31:0]       client_addr;
  logic [DATA_W-1:0] client_dout;
  logic              client_frame_done;
  logic              client_irq;
  logic              front_sel;
  logic              swap_pending;
  logic [15:0]       frame_count;
  logic [7:0]        swap_dropped;

  modport master (
    output host_we, host_addr, host_din, host_swap_req, client_addr, client_frame_done,
    input  host_dout, host_ready, client_dout, client_irq, front_sel, swap_pending,
           frame_count, swap_dropped
  );

  modport slave (
    input  host_we, host_addr, host_din, host_swap_req, client_addr, client_frame_done,
    output host_dout, host_ready, client_dout, client_irq, front_sel, swap_pending,
           frame_count, swap_dropped
  );
endinterface

// File: rtl/frame_swap_share.sv
// Double-buffered host/client shared memory with frame-synchronous bank swap,
// optional copy-on-swap refresh of the back bank, swap interrupt and statistics.
module frame_swap_share #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter bit COPY_ON_SWAP = 1'b0
) (
  input logic               clk,
  input logic               reset,
  frame_swap_share_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, PEND, COPY, COPY_PEND} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];
  logic              r_front_sel;
  logic [ADDR_W-1:0] r_copy_idx;
  logic [15:0]       r_frame_count;
  logic [7:0]        r_swap_dropped;
  logic              r_client_irq;
  logic [DATA_W-1:0] r_host_dout;
  logic [DATA_W-1:0] r_client_dout;

  logic [ADDR_W-1:0] w_host_word;
  logic [ADDR_W-1:0] w_client_word;
  logic              w_copying;
  logic              w_copy_last;
  logic              w_swap;
  logic              w_drop;
  logic              w_mem_we;
  logic [ADDR_W:0]   w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_unused_addr_bits;

  // Word index only; upper byte-address bits alias modulo DEPTH.
  assign w_host_word        = bus.host_addr[ADDR_W+1:2];
  assign w_client_word      = bus.client_addr[ADDR_W+1:2];
  assign w_unused_addr_bits = ^{bus.host_addr[31:ADDR_W+2], bus.host_addr[1:0],
                                bus.client_addr[31:ADDR_W+2], bus.client_addr[1:0]};

  assign w_copying   = (r_state == COPY) || (r_state == COPY_PEND);
  assign w_copy_last = (r_copy_idx == '1);

  // Swap-control FSM: next state, swap event and dropped-request strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.host_swap_req) w_state_nxt = PEND;
      end
      PEND: begin
        if (bus.host_swap_req) w_drop = 1'b1;
        if (bus.client_frame_done) begin
          w_swap      = 1'b1;
          w_state_nxt = COPY_ON_SWAP ? COPY : IDLE;
        end
      end
      COPY: begin
        if (w_copy_last)            w_state_nxt = bus.host_swap_req ? PEND : IDLE;
        else if (bus.host_swap_req) w_state_nxt = COPY_PEND;
      end
      COPY_PEND: begin
        if (bus.host_swap_req) w_drop = 1'b1;
        if (w_copy_last) w_state_nxt = PEND;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single write port: the copy engine owns it while copying, otherwise the host.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = {~r_front_sel, w_host_word};
    w_mem_wdata = bus.host_din;
    if (w_copying) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = {~r_front_sel, r_copy_idx};
      w_mem_wdata = r_mem[{r_front_sel, r_copy_idx}];
    end else if (bus.host_we) begin
      w_mem_we = 1'b1;
    end
  end

  // Bank storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  // Control state, counters and registered read ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_front_sel    <= 1'b0;
      r_copy_idx     <= '0;
      r_frame_count  <= '0;
      r_swap_dropped <= '0;
      r_client_irq   <= 1'b0;
      r_host_dout    <= '0;
      r_client_dout  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_client_irq  <= w_swap;
      r_host_dout   <= r_mem[{~r_front_sel, w_host_word}];
      r_client_dout <= r_mem[{r_front_sel, w_client_word}];
      if (w_swap) begin
        r_front_sel   <= ~r_front_sel;
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_drop && (r_swap_dropped != '1)) r_swap_dropped <= r_swap_dropped + 8'd1;
      if (w_copying) r_copy_idx <= r_copy_idx + ADDR_W'(1);
      else           r_copy_idx <= '0;
    end
  end

  assign bus.host_dout    = r_host_dout;
  assign bus.client_dout  = r_client_dout;
  assign bus.host_ready   = ~w_copying;
  assign bus.client_irq   = r_client_irq;
  assign bus.front_sel    = r_front_sel;
  assign bus.swap_pending = (r_state == PEND) || (r_state == COPY_PEND);
  assign bus.frame_count  = r_frame_count;
  assign bus.swap_dropped = r_swap_dropped;
endmodule

// File: tb/tb_frame_swap_share.sv
// Bench: two instances (plain 1024-word, copy-on-swap 16-word) driven by the
// same stimulus, checked against a bank-level behavioural model every cycle
// plus directed sequences for the swap, saturation, copy and reset cases.
module tb_frame_swap_share;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst = 1'b0;
  logic        s_we = 1'b0, s_req = 1'b0, s_fd = 1'b0;
  logic [31:0] s_addr = '0, s_din = '0, s_caddr = '0;

  frame_swap_share_if #(.DATA_W(32)) if0 ();
  frame_swap_share_if #(.DATA_W(32)) if1 ();

  frame_swap_share #(.DATA_W(32), .ADDR_W(10), .COPY_ON_SWAP(1'b0)) u_dut0 (
    .clk(clk), .reset(s_rst), .bus(if0));
  frame_swap_share #(.DATA_W(32), .ADDR_W(4), .COPY_ON_SWAP(1'b1)) u_dut1 (
    .clk(clk), .reset(s_rst), .bus(if1));

  assign if0.host_we = s_we;   assign if1.host_we = s_we;
  assign if0.host_addr = s_addr; assign if1.host_addr = s_addr;
  assign if0.host_din = s_din;  assign if1.host_din = s_din;
  assign if0.host_swap_req = s_req; assign if1.host_swap_req = s_req;
  assign if0.client_addr = s_caddr; assign if1.client_addr = s_caddr;
  assign if0.client_frame_done = s_fd; assign if1.client_frame_done = s_fd;

  logic        a_front [2], a_pend [2], a_irq [2], a_ready [2];
  logic [15:0] a_cnt [2];
  logic [7:0]  a_drop [2];
  logic [31:0] a_hd [2], a_cd [2];
  assign a_front[0] = if0.front_sel;    assign a_front[1] = if1.front_sel;
  assign a_pend[0]  = if0.swap_pending; assign a_pend[1]  = if1.swap_pending;
  assign a_irq[0]   = if0.client_irq;   assign a_irq[1]   = if1.client_irq;
  assign a_ready[0] = if0.host_ready;   assign a_ready[1] = if1.host_ready;
  assign a_cnt[0]   = if0.frame_count;  assign a_cnt[1]   = if1.frame_count;
  assign a_drop[0]  = if0.swap_dropped; assign a_drop[1]  = if1.swap_dropped;
  assign a_hd[0]    = if0.host_dout;    assign a_hd[1]    = if1.host_dout;
  assign a_cd[0]    = if0.client_dout;  assign a_cd[1]    = if1.client_dout;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model (bank arrays + pending flag + busy time)
  int          dep [2] = '{1024, 16};
  bit          cop [2] = '{1'b0, 1'b1};
  logic [31:0] m_mem [2][2][1024];
  bit          m_kn  [2][2][1024];
  int          m_front [2], m_busy [2], m_cnt [2], m_drop [2];
  bit          m_pend [2], m_irq [2], m_hk [2], m_ck [2];
  logic [31:0] m_hd [2], m_cd [2];

  task automatic copy_words(input int u, input int n);
    int fb, bb;
    fb = m_front[u]; bb = 1 - fb;
    for (int w = 0; w < n; w++) begin
      m_mem[u][bb][w] = m_mem[u][fb][w];
      m_kn[u][bb][w]  = m_kn[u][fb][w];
    end
  endtask

  task automatic model_step(input int u);
    int ha, ca, fb, bb;
    ha = int'(s_addr[31:2]) % dep[u];
    ca = int'(s_caddr[31:2]) % dep[u];
    fb = m_front[u]; bb = 1 - fb;
    m_irq[u] = 1'b0;
    if (m_busy[u] == 0) begin
      m_hd[u] = m_mem[u][bb][ha]; m_hk[u] = m_kn[u][bb][ha];
    end else begin
      m_hk[u] = 1'b0;
    end
    m_cd[u] = m_mem[u][fb][ca]; m_ck[u] = m_kn[u][fb][ca];
    if (m_busy[u] > 0) begin
      m_busy[u]--;
      if (s_req) begin
        if (m_pend[u]) m_drop[u] = (m_drop[u] < 255) ? m_drop[u] + 1 : 255;
        else           m_pend[u] = 1'b1;
      end
      if (m_busy[u] == 0) copy_words(u, dep[u]);
    end else begin
      if (s_we) begin m_mem[u][bb][ha] = s_din; m_kn[u][bb][ha] = 1'b1; end
      if (m_pend[u]) begin
        if (s_req) m_drop[u] = (m_drop[u] < 255) ? m_drop[u] + 1 : 255;
        if (s_fd) begin
          m_front[u] = bb;
          m_irq[u]   = 1'b1;
          m_cnt[u]   = (m_cnt[u] + 1) % 65536;
          m_pend[u]  = 1'b0;
          if (cop[u]) m_busy[u] = dep[u];
        end
      end else if (s_req) begin
        m_pend[u] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge s_rst) begin
    for (int u = 0; u < 2; u++) begin
      if (!s_rst) begin
        if (m_busy[u] > 0) copy_words(u, dep[u] - m_busy[u]);
        m_busy[u] = 0; m_front[u] = 0; m_pend[u] = 1'b0; m_cnt[u] = 0; m_drop[u] = 0;
        m_irq[u] = 1'b0; m_hd[u] = '0; m_cd[u] = '0; m_hk[u] = 1'b1; m_ck[u] = 1'b1;
      end else begin
        model_step(u);
      end
    end
  end

  // ---------------- checking helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_front_sel", u),    32'(a_front[u]), 32'(m_front[u]));
      chk($sformatf("u%0d_swap_pending", u), 32'(a_pend[u]),  32'(m_pend[u]));
      chk($sformatf("u%0d_client_irq", u),   32'(a_irq[u]),   32'(m_irq[u]));
      chk($sformatf("u%0d_host_ready", u),   32'(a_ready[u]), 32'(m_busy[u] == 0));
      chk($sformatf("u%0d_frame_count", u),  32'(a_cnt[u]),   32'(m_cnt[u]));
      chk($sformatf("u%0d_swap_dropped", u), 32'(a_drop[u]),  32'(m_drop[u]));
      if (m_hk[u]) chk($sformatf("u%0d_host_dout", u),   a_hd[u], m_hd[u]);
      if (m_ck[u]) chk($sformatf("u%0d_client_dout", u), a_cd[u], m_cd[u]);
    end
  endtask

  task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input bit rq, input bit fd, input logic [31:0] ca);
    s_we = we; s_addr = a; s_din = d; s_req = rq; s_fd = fd; s_caddr = ca;
    @(negedge clk);
    model_check();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_ready1();
    int k;
    k = 0;
    while (!a_ready[1] && k < 64) begin idle(); k++; end
    chk("wait_copy_done", 32'(a_ready[1]), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_u%0d_front", tag, u), 32'(a_front[u]), 32'd0);
      chk($sformatf("%s_u%0d_pend", tag, u),  32'(a_pend[u]),  32'd0);
      chk($sformatf("%s_u%0d_irq", tag, u),   32'(a_irq[u]),   32'd0);
      chk($sformatf("%s_u%0d_ready", tag, u), 32'(a_ready[u]), 32'd1);
      chk($sformatf("%s_u%0d_cnt", tag, u),   32'(a_cnt[u]),   32'd0);
      chk($sformatf("%s_u%0d_drop", tag, u),  32'(a_drop[u]),  32'd0);
      chk($sformatf("%s_u%0d_hdout", tag, u), a_hd[u], 32'd0);
      chk($sformatf("%s_u%0d_cdout", tag, u), a_cd[u], 32'd0);
    end
  endtask

  typedef struct {
    bit          req;
    bit          fd;
    bit          e_pend;
    bit          e_front;
    bit          e_irq;
    logic [15:0] e_cnt;
  } swap_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    swap_vec_t tbl [9];
    int lowc, irqs;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};

    // Reset state
    repeat (3) idle();
    chk_reset_vals("reset");
    s_rst = 1'b1;

    // Preload: B1 <- 0xB000_0000|i, swap, B0 <- 0xA000_0000|i, then reset
    for (int i = 0; i < 1024; i++) cyc(1'b1, 32'(i * 4), 32'hB000_0000 | 32'(i), 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, '0);
    repeat (20) idle();
    for (int i = 0; i < 1024; i++) cyc(1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b0, 1'b0, '0);
    s_rst = 1'b0; idle(); s_rst = 1'b1; idle();

    // Host fill of back bank B1 and readback; client still sees B0
    for (int i = 0; i < 1024; i++) cyc(1'b1, 32'(i * 4), 32'(i * 3), 1'b0, 1'b0, '0);
    cyc(1'b1, 32'd20, 32'h0000_1234, 1'b0, 1'b0, '0);
    cyc(1'b0, 32'd20, '0, 1'b0, 1'b0, '0);
    chk("wr_then_rd", if0.host_dout, 32'h0000_1234);
    cyc(1'b1, 32'd20, 32'd15, 1'b0, 1'b0, '0);
    cyc(1'b0, 32'h8000_1017, '0, 1'b0, 1'b0, 32'hFFFF_F018);
    chk("alias_host", if0.host_dout, 32'd15);
    chk("alias_client", if0.client_dout, 32'hA000_0006);
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b0, 32'(i * 4), '0, 1'b0, 1'b0, 32'(i * 4));
      chk("host_rd_b1", if0.host_dout, 32'(i * 3));
      chk("client_rd_b0", if0.client_dout, 32'hA000_0000 | 32'(i));
    end

    // Table-driven swap handshake on the plain instance
    for (int r = 0; r < 9; r++) begin
      cyc(1'b0, '0, '0, tbl[r].req, tbl[r].fd, 32'd40);
      chk($sformatf("tbl%0d_pend", r),  32'(if0.swap_pending), 32'(tbl[r].e_pend));
      chk($sformatf("tbl%0d_front", r), 32'(if0.front_sel),    32'(tbl[r].e_front));
      chk($sformatf("tbl%0d_irq", r),   32'(if0.client_irq),   32'(tbl[r].e_irq));
      chk($sformatf("tbl%0d_cnt", r),   32'(if0.frame_count),  32'(tbl[r].e_cnt));
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 32'd40);
    chk("client_new_front", if0.client_dout, 32'd30);

    // Dropped-request saturation, then exactly one swap
    wait_ready1();
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 300; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
    chk("drop_sat_u0", 32'(if0.swap_dropped), 32'd255);
    chk("drop_sat_u1", 32'(if1.swap_dropped), 32'd255);
    chk("pend_held", 32'(if0.swap_pending), 32'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, '0);
    irqs = int'(if0.client_irq);
    chk("sat_swap_cnt", 32'(if0.frame_count), 32'd2);
    chk("sat_swap_front", 32'(if0.front_sel), 32'd0);
    repeat (4) begin idle(); irqs += int'(if0.client_irq); end
    chk("sat_single_irq", 32'(irqs), 32'd1);

    // Copy-on-swap: busy window length, write dropped during copy, back == front
    wait_ready1();
    for (int w = 0; w < 16; w++) cyc(1'b1, 32'(w * 4), $urandom(), 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, '0);
    lowc = 0;
    for (int k = 0; k < 40 && !if1.host_ready; k++) begin
      lowc++;
      cyc(k == 2, 32'd12, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    end
    chk("copy_busy_cycles", 32'(lowc), 32'd16);
    for (int w = 0; w < 16; w++) begin
      cyc(1'b0, 32'(w * 4), '0, 1'b0, 1'b0, 32'(w * 4));
      chk("copy_back_eq_front", if1.host_dout, m_mem[1][m_front[1]][w]);
    end

    // Swap request during copy; frame_done mid-copy ignored
    wait_ready1();
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, '0);
    chk("cp_first_front", 32'(if1.front_sel), 32'd0);
    for (int k = 0; k < 40 && !if1.host_ready; k++) begin
      cyc(1'b0, '0, '0, k == 3, k == 8, '0);
      if (k == 8) begin
        chk("cp_mid_front", 32'(if1.front_sel), 32'd0);
        chk("cp_mid_irq", 32'(if1.client_irq), 32'd0);
        chk("cp_mid_pend", 32'(if1.swap_pending), 32'd1);
      end
    end
    chk("cp_after_ready", 32'(if1.host_ready), 32'd1);
    chk("cp_after_pend", 32'(if1.swap_pending), 32'd1);
    chk("cp_after_front", 32'(if1.front_sel), 32'd0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, '0);
    chk("cp_swap_front", 32'(if1.front_sel), 32'd1);
    chk("cp_swap_irq", 32'(if1.client_irq), 32'd1);
    chk("cp_swap_cnt", 32'(if1.frame_count), 32'd5);

    // Reset at word 7 of a copy
    wait_ready1();
    for (int w = 0; w < 16; w++) cyc(1'b1, 32'(w * 4), 32'h7700_0000 | 32'(w), 1'b0, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, '0);
    repeat (7) idle();
    #2 s_rst = 1'b0;
    #1 chk_reset_vals("midcopy");
    idle();
    s_rst = 1'b1;
    idle();
    for (int w = 0; w < 16; w++) begin
      cyc(1'b0, 32'(w * 4), '0, 1'b0, 1'b0, 32'(w * 4));
      chk("partial_copy", if1.host_dout, m_mem[1][1 - m_front[1]][w]);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom(), $urandom(),
          $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
